// File: rtl/line_setup.sv
// line_setup: vector line setup stage feeding the Bresenham rasterizer.
// Takes one line (endpoints + intensity) and computes the absolute deltas,
// the major axis, the step directions and the Bresenham error terms. The
// result is held on a level-valid handshake until the rasterizer reports
// idle. All outputs are driven straight from flops.
//
// Optional feature macro: LINE_SETUP_CULL_EN
//   When defined, zero-length lines are dropped in SETUP and never
//   presented to the rasterizer.
//   When undefined, they are forwarded with denominator = 0.
module line_setup #(
  parameter int CW = 12,
  parameter int IW = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 vecValid,
  output logic                 vecReady,
  input  logic [CW-1:0]        x0,
  input  logic [CW-1:0]        y0,
  input  logic [CW-1:0]        x1,
  input  logic [CW-1:0]        y1,
  input  logic [IW-1:0]        intensity,
  output logic                 lineValid,
  input  logic                 rastReady,
  output logic [CW:0]          denominator,
  output logic [CW-1:0]        startX,
  output logic [CW-1:0]        startY,
  output logic                 stepX,
  output logic                 stepY,
  output logic                 yMajor,
  output logic signed [CW+2:0] errInit,
  output logic signed [CW+2:0] errInc,
  output logic signed [CW+2:0] errDec,
  output logic [IW-1:0]        lineIntensity
);

  localparam int EW = CW + 3;

  typedef enum logic [1:0] {IDLE, CALC, SETUP, HOLD} state_e;

  state_e               state_q, state_d;
  logic [CW-1:0]        x0_q, x0_d, y0_q, y0_d, x1_q, x1_d, y1_q, y1_d;
  logic [IW-1:0]        int_q, int_d;
  logic [CW:0]          adx_q, adx_d, ady_q, ady_d;
  logic                 step_x_q, step_x_d, step_y_q, step_y_d;
  logic [CW:0]          den_q, den_d;
  logic                 y_major_q, y_major_d;
  logic signed [EW-1:0] err_init_q, err_init_d;
  logic signed [EW-1:0] err_inc_q, err_inc_d;
  logic signed [EW-1:0] err_dec_q, err_dec_d;
  logic                 line_valid_q, line_valid_d;
  logic                 vec_ready_q, vec_ready_d;

  // Scratch values used only inside the next-state logic.
  logic [CW:0]          dx, dy;
  logic                 y_maj;
  logic [CW:0]          major, minor;
  logic signed [EW-1:0] maj_s, min_s;
  logic                 zero_len;

  // Next-state and datapath computation for every register.
  always_comb begin
    // NOTE: every value gets a default first so no path can leave a
    // variable unassigned and infer a latch.
    state_d      = state_q;
    x0_d         = x0_q;
    y0_d         = y0_q;
    x1_d         = x1_q;
    y1_d         = y1_q;
    int_d        = int_q;
    adx_d        = adx_q;
    ady_d        = ady_q;
    step_x_d     = step_x_q;
    step_y_d     = step_y_q;
    den_d        = den_q;
    y_major_d    = y_major_q;
    err_init_d   = err_init_q;
    err_inc_d    = err_inc_q;
    err_dec_d    = err_dec_q;

    // Two's-complement deltas, one bit wider than a coordinate.
    dx       = {1'b0, x1_q} - {1'b0, x0_q};
    dy       = {1'b0, y1_q} - {1'b0, y0_q};
    // A tie between the deltas selects x-major.
    y_maj    = (ady_q > adx_q);
    major    = y_maj ? ady_q : adx_q;
    minor    = y_maj ? adx_q : ady_q;
    // Both magnitudes are non-negative, so zero-extension is the sign
    // extension; two extra bits leave room for 2*minor without overflow.
    maj_s    = signed'({2'b00, major});
    min_s    = signed'({2'b00, minor});
    zero_len = (adx_q == '0) && (ady_q == '0);

    unique case (state_q)
      IDLE: begin
        if (vecValid) begin
          x0_d    = x0;
          y0_d    = y0;
          x1_d    = x1;
          y1_d    = y1;
          int_d   = intensity;
          state_d = CALC;
        end
      end
      CALC: begin
        adx_d    = dx[CW] ? (~dx + 1'b1) : dx;
        ady_d    = dy[CW] ? (~dy + 1'b1) : dy;
        step_x_d = dx[CW];
        step_y_d = dy[CW];
        state_d  = SETUP;
      end
      SETUP: begin
        y_major_d  = y_maj;
        den_d      = major;
        err_init_d = min_s + min_s - maj_s;
        err_inc_d  = min_s + min_s;
        err_dec_d  = min_s + min_s - maj_s - maj_s;
`ifdef LINE_SETUP_CULL_EN
        state_d    = zero_len ? IDLE : HOLD;
`else
        state_d    = HOLD;
`endif
      end
      HOLD: begin
        // lineValid is high throughout HOLD, so rastReady alone completes
        // the transfer here.
        if (rastReady) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // Handshake flags follow the next state so they come straight from flops.
    line_valid_d = (state_d == HOLD);
    vec_ready_d  = (state_d == IDLE);
  end

`ifndef LINE_SETUP_CULL_EN
  // The zero-length flag only steers the cull path; this keeps it read
  // in the default build.
  logic unused_zero_len;
  assign unused_zero_len = zero_len;
`endif

  // State and output registers; reset discards any line in flight.
  // NOTE: the reset is asynchronous, so an in-flight line is cleared at
  // once, without waiting for a clock edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      x0_q         <= '0;
      y0_q         <= '0;
      x1_q         <= '0;
      y1_q         <= '0;
      int_q        <= '0;
      adx_q        <= '0;
      ady_q        <= '0;
      step_x_q     <= 1'b0;
      step_y_q     <= 1'b0;
      den_q        <= '0;
      y_major_q    <= 1'b0;
      err_init_q   <= '0;
      err_inc_q    <= '0;
      err_dec_q    <= '0;
      line_valid_q <= 1'b0;
      vec_ready_q  <= 1'b1;
    end else begin
      // NOTE: non-blocking assignments make every flop sample pre-edge values.
      state_q      <= state_d;
      x0_q         <= x0_d;
      y0_q         <= y0_d;
      x1_q         <= x1_d;
      y1_q         <= y1_d;
      int_q        <= int_d;
      adx_q        <= adx_d;
      ady_q        <= ady_d;
      step_x_q     <= step_x_d;
      step_y_q     <= step_y_d;
      den_q        <= den_d;
      y_major_q    <= y_major_d;
      err_init_q   <= err_init_d;
      err_inc_q    <= err_inc_d;
      err_dec_q    <= err_dec_d;
      line_valid_q <= line_valid_d;
      vec_ready_q  <= vec_ready_d;
    end
  end

  assign vecReady      = vec_ready_q;
  assign lineValid     = line_valid_q;
  assign denominator   = den_q;
  assign startX        = x0_q;
  assign startY        = y0_q;
  assign stepX         = step_x_q;
  assign stepY         = step_y_q;
  assign yMajor        = y_major_q;
  assign errInit       = err_init_q;
  assign errInc        = err_inc_q;
  assign errDec        = err_dec_q;
  assign lineIntensity = int_q;

endmodule

// File: tb/tb_line_setup.sv
// tb_line_setup: directed, table-driven bench for line_setup. It also covers
// reset mid-line, the stalled handshake and zero-length lines, with the
// expected behaviour following LINE_SETUP_CULL_EN.
module tb_line_setup;

  localparam int CW = 12;
  localparam int IW = 4;

  logic                 clk = 1'b0;
  logic                 rst_n;
  logic                 vecValid;
  logic                 vecReady;
  logic [CW-1:0]        x0, y0, x1, y1;
  logic [IW-1:0]        intensity;
  logic                 lineValid;
  logic                 rastReady;
  logic [CW:0]          denominator;
  logic [CW-1:0]        startX, startY;
  logic                 stepX, stepY, yMajor;
  logic signed [CW+2:0] errInit, errInc, errDec;
  logic [IW-1:0]        lineIntensity;

  int checks = 0;
  int errors = 0;

  line_setup #(.CW(CW), .IW(IW)) dut (
    .clk(clk), .rst_n(rst_n),
    .vecValid(vecValid), .vecReady(vecReady),
    .x0(x0), .y0(y0), .x1(x1), .y1(y1), .intensity(intensity),
    .lineValid(lineValid), .rastReady(rastReady),
    .denominator(denominator), .startX(startX), .startY(startY),
    .stepX(stepX), .stepY(stepY), .yMajor(yMajor),
    .errInit(errInit), .errInc(errInc), .errDec(errDec),
    .lineIntensity(lineIntensity)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [CW-1:0] x0, y0, x1, y1;
    logic [IW-1:0] inten;
    int            den;
    bit            ym, sx, sy;
    int            ei, einc, edec;
    bit            rr_early;  // hold rastReady high from before the accept
    int            stall;     // cycles to hold rastReady low in HOLD
  } vec_t;

  vec_t vecs[6];

  task automatic check(input string name, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_lineValid"}, lineValid, 0);
    check({tag, "_vecReady"}, vecReady, 1);
    check({tag, "_den"}, denominator, 0);
    check({tag, "_startX"}, startX, 0);
    check({tag, "_startY"}, startY, 0);
    check({tag, "_flags"}, {stepX, stepY, yMajor}, 0);
    check({tag, "_errInit"}, $signed(errInit), 0);
    check({tag, "_errInc"}, $signed(errInc), 0);
    check({tag, "_errDec"}, $signed(errDec), 0);
    check({tag, "_int"}, lineIntensity, 0);
  endtask

  // Present a line at the next negedge so it is accepted on the next posedge,
  // then scramble the inputs to show they are not sampled again.
  task automatic accept_line(input vec_t v);
    int n = 0;
    while (!vecReady && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("ready_before_accept", vecReady, 1);
    x0 = v.x0; y0 = v.y0; x1 = v.x1; y1 = v.y1; intensity = v.inten;
    vecValid = 1'b1;
    rastReady = v.rr_early;
    @(posedge clk);
    @(negedge clk);
    vecValid = 1'b0;
    x0 = ~v.x0; y0 = ~v.y0; x1 = ~v.x1; y1 = ~v.y1; intensity = ~v.inten;
  endtask

  // Count negedges after the accept until lineValid (negedge 1 follows edge N).
  task automatic wait_valid(output int n);
    n = 1;
    while (!lineValid && n < 12) begin
      check("ready_low_busy", vecReady, 0);
      @(negedge clk);
      n++;
    end
  endtask

  task automatic check_result(input string tag, input vec_t v);
    check({tag, "_den"}, denominator, v.den);
    check({tag, "_yMajor"}, yMajor, v.ym);
    check({tag, "_stepX"}, stepX, v.sx);
    check({tag, "_stepY"}, stepY, v.sy);
    check({tag, "_errInit"}, $signed(errInit), v.ei);
    check({tag, "_errInc"}, $signed(errInc), v.einc);
    check({tag, "_errDec"}, $signed(errDec), v.edec);
    check({tag, "_startX"}, startX, v.x0);
    check({tag, "_startY"}, startY, v.y0);
    check({tag, "_int"}, lineIntensity, v.inten);
  endtask

  task automatic run_vec(input vec_t v);
    int n;
    accept_line(v);
    wait_valid(n);
    check("latency", n, 3);
    check("valid_seen", lineValid, 1);
    check("ready_in_hold", vecReady, 0);
    check_result("res", v);
    for (int i = 0; i < v.stall; i++) begin
      @(negedge clk);
      check("stall_valid", lineValid, 1);
      check("stall_ready", vecReady, 0);
      check_result("stall", v);
    end
    rastReady = 1'b1;
    @(negedge clk);
    check("post_xfer_valid", lineValid, 0);
    check("post_xfer_ready", vecReady, 1);
    rastReady = 1'b0;
  endtask

  initial begin
    int n;
    vec_t z;

    //             x0    y0    x1    y1   int  den  ym sx sy    ei   einc   edec  rr  stall
    vecs[0] = '{  10,   20,  110,   60, 4'h7,  100, 0, 0, 0,   -20,   80,  -120, 1,  0};
    vecs[1] = '{ 200,  300,  150,  100, 4'hA,  200, 1, 1, 1,  -100,  100,  -300, 0,  0};
    vecs[2] = '{   0,    0, 4095, 4095, 4'hF, 4095, 0, 0, 0,  4095, 8190,     0, 0,  0};
    vecs[3] = '{4095,    0,    0,    0, 4'h1, 4095, 0, 1, 0, -4095,    0, -8190, 1,  0};
    vecs[4] = '{ 100,  100,  103,   90, 4'h3,   10, 1, 0, 1,    -4,    6,   -14, 0, 20};
    vecs[5] = '{  50,   10,   40,   15, 4'h5,   10, 0, 1, 0,     0,   10,   -10, 1,  0};

    rst_n = 1'b0; vecValid = 1'b0; rastReady = 1'b0;
    x0 = '0; y0 = '0; x1 = '0; y1 = '0; intensity = '0;

    // Reset state, with a handshake attempted while in reset.
    #12;
    vecValid = 1'b1; x0 = 12'd7; x1 = 12'd9;
    @(negedge clk);
    check_all_zero("reset");
    vecValid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("after_reset_ready", vecReady, 1);
    check("after_reset_valid", lineValid, 0);

    for (int i = 0; i < 6; i++) run_vec(vecs[i]);

    // Reset asserted in HOLD with the rasterizer busy.
    accept_line(vecs[1]);
    wait_valid(n);
    check("rst_mid_reached_hold", lineValid, 1);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1 check_all_zero("rst_mid");
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_mid_release_ready", vecReady, 1);
    check("rst_mid_release_valid", lineValid, 0);

    // Zero-length line.
    z = '{5, 5, 5, 5, 4'h9, 0, 0, 0, 0, 0, 0, 0, 0, 0};
    accept_line(z);
`ifdef LINE_SETUP_CULL_EN
    for (int k = 1; k <= 5; k++) begin
      check("cull_no_valid", lineValid, 0);
      check("cull_ready", vecReady, (k >= 3) ? 1 : 0);
      @(negedge clk);
    end
`else
    run_vec_tail(z);
`endif

    // The block accepts again after the zero-length case.
    run_vec(vecs[0]);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Tail of run_vec for a line already accepted by the caller.
  task automatic run_vec_tail(input vec_t v);
    int n;
    wait_valid(n);
    check("zero_latency", n, 3);
    check("zero_valid", lineValid, 1);
    check_result("zero", v);
    rastReady = 1'b1;
    @(negedge clk);
    check("zero_post_valid", lineValid, 0);
    check("zero_post_ready", vecReady, 1);
    rastReady = 1'b0;
  endtask

endmodule
